// File: rtl/face_coords_if.sv
// Result bus from the Viola-Jones pipeline into the UART result transmitter.
interface face_coords_if;
  logic [1:0][31:0] face_coords;
  logic             face_coords_ready;
  logic [3:0]       pyramid_number;
  logic             vj_pipeline_done;

  modport master (
    output face_coords,
    output face_coords_ready,
    output pyramid_number,
    output vj_pipeline_done
  );

  modport slave (
    input face_coords,
    input face_coords_ready,
    input pyramid_number,
    input vj_pipeline_done
  );
endinterface

// File: rtl/face_coords_tx.sv
// Buffers face-detection results in a FIFO and streams them as 6-byte UART packets,
// followed by a 2-byte frame terminator (0xFE, count) after each completed image scan.
module face_coords_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clock,
  input  logic         reset,
  face_coords_if.slave res_if,
  output logic         uart_tx,
  output logic         tx_busy,
  output logic         overflow
);
  localparam int          AW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST_C = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  // Entry layout: {pyramid[35:32], row[31:16], col[15:0]}; terminator keeps its count in [7:0].
  function automatic logic [7:0] pkt_byte(input logic is_term, input logic [2:0] idx,
                                          input logic [35:0] e);
    logic [7:0] b;
    if (is_term) begin
      b = (idx == 3'd0) ? 8'hFE : e[7:0];
    end else begin
      case (idx)
        3'd0:    b = 8'hFA;
        3'd1:    b = {4'h0, e[35:32]};
        3'd2:    b = e[31:24];
        3'd3:    b = e[23:16];
        3'd4:    b = e[15:8];
        3'd5:    b = e[7:0];
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

  logic [35:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    byte_q, byte_d;
  logic [35:0]   pkt_q, pkt_d;
  logic          term_q, term_d;
  logic          tx_q, tx_d;
  logic [7:0]    frame_q, frame_d;
  logic          flag_q, flag_d;
  logic          done_prev_q;
  logic          ovf_q, ovf_d;

  logic          empty_s, full_s, push_s, pop_s, drop_s;
  logic          done_rise_s, flag_clr_s, bit_end_s;
  logic [2:0]    last_idx_s;
  logic [35:0]   entry_s;
  logic          unused_s;

  assign entry_s     = {res_if.pyramid_number, res_if.face_coords[0][15:0],
                        res_if.face_coords[1][15:0]};
  assign unused_s    = &{1'b0, res_if.face_coords[0][31:16], res_if.face_coords[1][31:16]};
  assign empty_s     = (count_q == '0);
  assign full_s      = (count_q == DEPTH_C);
  assign pop_s       = (state_q == LOAD) && !empty_s;
  assign push_s      = res_if.face_coords_ready && (!full_s || pop_s);
  assign drop_s      = res_if.face_coords_ready && full_s && !pop_s;
  assign done_rise_s = res_if.vj_pipeline_done && !done_prev_q;
  assign bit_end_s   = (baud_q == BIT_LAST_C);
  assign last_idx_s  = term_q ? 3'd1 : 3'd5;

  // FIFO pointer, occupancy, sticky overflow and terminator-request bookkeeping.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | drop_s;
    // A done edge arriving while a terminator is already pending is ignored.
    if (flag_clr_s) begin
      flag_d = 1'b0;
    end else if (done_rise_s) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_q;
    end
  end

  // Packet/byte/bit sequencer driving the serial line.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    byte_d     = byte_q;
    pkt_d      = pkt_q;
    term_d     = term_q;
    tx_d       = tx_q;
    frame_d    = frame_q;
    flag_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty_s || flag_q) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Queued results always go ahead of the terminator.
        if (!empty_s) begin
          pkt_d  = mem_q[rd_ptr_q];
          term_d = 1'b0;
          byte_d = 8'hFA;
        end else begin
          pkt_d      = {28'h0, frame_q};
          term_d     = 1'b1;
          byte_d     = 8'hFE;
          frame_d    = 8'h00;
          flag_clr_s = 1'b1;
        end
        byte_idx_d = 3'd0;
        baud_d     = 16'd0;
        tx_d       = 1'b0;
        state_d    = START;
      end
      START: begin
        if (bit_end_s) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = byte_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_d = 16'd0;
          if (byte_idx_q == last_idx_s) begin
            state_d = IDLE;
            if (!term_q && (frame_q != 8'hFF)) begin
              frame_d = frame_q + 8'd1;
            end else begin
              frame_d = frame_q;
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            byte_d     = pkt_byte(term_q, byte_idx_q + 3'd1, pkt_q);
            tx_d       = 1'b0;
            state_d    = START;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      baud_q      <= 16'd0;
      bit_q       <= 3'd0;
      byte_idx_q  <= 3'd0;
      byte_q      <= 8'h00;
      pkt_q       <= 36'h0;
      term_q      <= 1'b0;
      tx_q        <= 1'b1;
      frame_q     <= 8'h00;
      flag_q      <= 1'b0;
      done_prev_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_idx_q  <= byte_idx_d;
      byte_q      <= byte_d;
      pkt_q       <= pkt_d;
      term_q      <= term_d;
      tx_q        <= tx_d;
      frame_q     <= frame_d;
      flag_q      <= flag_d;
      done_prev_q <= res_if.vj_pipeline_done;
      ovf_q       <= ovf_d;
    end
  end

  assign uart_tx  = tx_q;
  assign overflow = ovf_q;
  assign tx_busy  = !empty_s || flag_q || (state_q != IDLE);
endmodule
